// File: rtl/aprecv_spi_pkg.sv
// Shared types and word width for the SPI result-transmit slice.
package aprecv_spi_pkg;

    localparam int APREC_WORD_W = 10;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_tx_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with one-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic main_clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   level_d;

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            stages  <= {SYNC_STAGES{RESET_VAL}};
            level_d <= RESET_VAL;
        end else begin
            stages  <= {stages[SYNC_STAGES-2:0], async_in};
            level_d <= stages[SYNC_STAGES-1];
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = level & ~level_d;
    assign fall  = ~level & level_d;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode-0 slave transmitter: buffers datapath words in a small FIFO and shifts them out MSB-first.
module spi_slave_tx
    import aprecv_spi_pkg::*;
#(
    parameter int DATA_W      = APREC_WORD_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sclk_i,
    input  logic              cs_i,
    output logic              sdo_o,
    output logic              frame_done_o,
    output logic              underrun_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .main_clk (main_clk),
        .rst      (rst),
        .async_in (sclk_i),
        .level    (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .main_clk (main_clk),
        .rst      (rst),
        .async_in (cs_i),
        .level    (cs_level),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop;

    assign ready_o = (count != CNT_W'(FIFO_DEPTH));
    assign push    = valid_i && ready_o;

    always_ff @(posedge main_clk) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    spi_tx_state_t     state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic [BIT_W-1:0]  bitcnt, bitcnt_next;
    logic              reload, reload_next;
    logic              frame_done_next, underrun_next;

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            bitcnt       <= '0;
            reload       <= 1'b0;
            frame_done_o <= 1'b0;
            underrun_o   <= 1'b0;
        end else begin
            state        <= state_next;
            shreg        <= shreg_next;
            bitcnt       <= bitcnt_next;
            reload       <= reload_next;
            frame_done_o <= frame_done_next;
            underrun_o   <= underrun_next;
        end
    end

    // A cs release overrides everything; the partially sent word is simply dropped.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bitcnt_next     = bitcnt;
        reload_next     = reload;
        frame_done_next = 1'b0;
        underrun_next   = 1'b0;
        pop             = 1'b0;
        if (cs_rise) begin
            state_next  = IDLE;
            bitcnt_next = '0;
            reload_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) state_next = LOAD;
                end
                LOAD: begin
                    if (count != '0) begin
                        pop        = 1'b1;
                        shreg_next = mem[rd_ptr];
                    end else begin
                        shreg_next    = '0;
                        underrun_next = 1'b1;
                    end
                    bitcnt_next = '0;
                    reload_next = 1'b0;
                    state_next  = SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        bitcnt_next = bitcnt + 1'b1;
                        if (bitcnt == BIT_W'(DATA_W - 1)) begin
                            frame_done_next = 1'b1;
                            reload_next     = 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (reload) state_next = LOAD;
                        else        shreg_next = {shreg[DATA_W-2:0], 1'b0};
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sdo_o = (state == SHIFT) && !cs_level && shreg[DATA_W-1];

endmodule
